// File: rtl/line_raster_stream_pkg.sv
// line_raster_stream_pkg: shared types and defaults for the line rasteriser.
//   state_e    : FSM states IDLE/SETUP/RUN/DONE (IDLE encodes as 0 so reset lands there)
//   step_t     : signed error/delta type for the default coordinate width (COORD_W+2 bits)
//   *_DEF      : default coordinate width and framebuffer dimensions
package raster_pkg;
    localparam int COORD_W_DEF = 8;
    localparam int FB_W_DEF    = 64;
    localparam int FB_H_DEF    = 64;
    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, RUN = 2'd2, DONE = 2'd3} state_e;
    typedef logic signed [COORD_W_DEF+1:0] step_t;
endpackage

// File: rtl/line_raster_stream_step.sv
// raster_step: one combinational Bresenham step.
//   err_i, dx_i, dy_i    : signed error term and absolute deltas
//   x_i, y_i             : current pixel
//   sx_neg_i, sy_neg_i   : step direction is -1 when set, +1 otherwise
//   err_o, x_o, y_o      : updated error and pixel after the step
module raster_step #(
    parameter int COORD_W = 8
) (
    input  logic signed [COORD_W+1:0] err_i,
    input  logic signed [COORD_W+1:0] dx_i,
    input  logic signed [COORD_W+1:0] dy_i,
    input  logic        [COORD_W-1:0] x_i,
    input  logic        [COORD_W-1:0] y_i,
    input  logic                      sx_neg_i,
    input  logic                      sy_neg_i,
    output logic signed [COORD_W+1:0] err_o,
    output logic        [COORD_W-1:0] x_o,
    output logic        [COORD_W-1:0] y_o
);
    logic signed [COORD_W+1:0] e2;
    logic step_x, step_y;

    // Both tests use the pre-step e2, so diagonal moves update x and y together.
    always_comb begin
        e2     = err_i <<< 1;
        step_x = e2 > -dy_i;
        step_y = e2 < dx_i;
        err_o  = err_i - (step_x ? dy_i : '0) + (step_y ? dx_i : '0);
        x_o    = step_x ? (sx_neg_i ? x_i - COORD_W'(1) : x_i + COORD_W'(1)) : x_i;
        y_o    = step_y ? (sy_neg_i ? y_i - COORD_W'(1) : y_i + COORD_W'(1)) : y_i;
    end
endmodule

// File: rtl/line_raster_stream.sv
// line_raster_stream: Bresenham line rasteriser streaming pixels over a valid/ready handshake.
//   clk, n_rst            : clock, asynchronous active-low reset
//   start, x0..y1, pattern: line command (sampled in IDLE only) and 8-bit dash mask
//   abort                 : cancel the current line (ignored in IDLE)
//   pix_valid/pix_ready   : pixel handshake; pix_x/pix_y/pix_addr/pix_last describe the pixel
//   busy, done, pix_count : status, completion pulse, accepted-pixel count
module line_raster_stream
    import raster_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int FB_W    = FB_W_DEF,
    parameter int FB_H    = FB_H_DEF,
    parameter int ADDR_W  = $clog2(FB_W*FB_H)
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic [7:0]         pattern,
    input  logic               abort,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [ADDR_W-1:0]  pix_addr,
    output logic               pix_last,
    output logic               busy,
    output logic               done,
    output logic [COORD_W+1:0] pix_count
);
    localparam int SW = COORD_W + 2;

    state_e state_q, state_d;
    logic [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d, xe_q, xe_d, ye_q, ye_d, nx, ny;
    logic [7:0] pat_q, pat_d;
    logic signed [SW-1:0] err_q, err_d, dx_q, dx_d, dy_q, dy_d, err_s;
    logic sxn_q, sxn_d, syn_q, syn_d;
    logic [2:0] k_q, k_d;
    logic [COORD_W+1:0] cnt_q, cnt_d;
    logic vis, last, adv;

    raster_step #(.COORD_W(COORD_W)) u_step (
        .err_i(err_q), .dx_i(dx_q), .dy_i(dy_q), .x_i(cx_q), .y_i(cy_q),
        .sx_neg_i(sxn_q), .sy_neg_i(syn_q), .err_o(err_s), .x_o(nx), .y_o(ny)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? SETUP : IDLE;
            SETUP:   state_d = RUN;
            RUN:     state_d = (adv && last) ? DONE : RUN;
            default: state_d = IDLE;
        endcase
        if (abort && state_q != IDLE) state_d = IDLE;
    end

    // A pixel advances when it is accepted or when it is hidden (off-screen or masked).
    always_comb begin
        vis       = 32'(cx_q) < FB_W && 32'(cy_q) < FB_H && pat_q[k_q];
        last      = cx_q == xe_q && cy_q == ye_q;
        busy      = state_q != IDLE;
        done      = state_q == DONE;
        pix_valid = state_q == RUN && vis;
        pix_last  = state_q == RUN && last;
        adv       = state_q == RUN && (!vis || pix_ready);
        pix_x     = cx_q;
        pix_y     = cy_q;
        pix_addr  = ADDR_W'(cy_q) * ADDR_W'(FB_W) + ADDR_W'(cx_q);
        pix_count = cnt_q;
    end

    // The start point is latched straight into the cursor; SETUP derives deltas from it.
    always_comb begin
        cx_d  = cx_q;
        cy_d  = cy_q;
        xe_d  = xe_q;
        ye_d  = ye_q;
        pat_d = pat_q;
        err_d = err_q;
        dx_d  = dx_q;
        dy_d  = dy_q;
        sxn_d = sxn_q;
        syn_d = syn_q;
        k_d   = k_q;
        cnt_d = cnt_q + (COORD_W+2)'(pix_valid && pix_ready);
        if (state_q == IDLE && start) begin
            cx_d  = x0;
            cy_d  = y0;
            xe_d  = x1;
            ye_d  = y1;
            pat_d = pattern;
            cnt_d = '0;
        end
        if (state_q == SETUP) begin
            dx_d  = xe_q > cx_q ? SW'(xe_q - cx_q) : SW'(cx_q - xe_q);
            dy_d  = ye_q > cy_q ? SW'(ye_q - cy_q) : SW'(cy_q - ye_q);
            sxn_d = !(xe_q > cx_q);
            syn_d = !(ye_q > cy_q);
            err_d = dx_d - dy_d;
            k_d   = '0;
        end
        if (adv && !last) begin
            cx_d  = nx;
            cy_d  = ny;
            err_d = err_s;
            k_d   = k_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cx_q  <= '0;
            cy_q  <= '0;
            xe_q  <= '0;
            ye_q  <= '0;
            pat_q <= '0;
            err_q <= '0;
            dx_q  <= '0;
            dy_q  <= '0;
            sxn_q <= 1'b0;
            syn_q <= 1'b0;
            k_q   <= '0;
            cnt_q <= '0;
        end else begin
            cx_q  <= cx_d;
            cy_q  <= cy_d;
            xe_q  <= xe_d;
            ye_q  <= ye_d;
            pat_q <= pat_d;
            err_q <= err_d;
            dx_q  <= dx_d;
            dy_q  <= dy_d;
            sxn_q <= sxn_d;
            syn_q <= syn_d;
            k_q   <= k_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: doc/line_raster_stream.md
LINE_RASTER_STREAM -- requirements
Module: line_raster_stream

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  COORD_W, 8, coordinate width in bits; coordinates are unsigned.
  FB_W, 64, framebuffer width in pixels.
  FB_H, 64, framebuffer height in pixels.
  ADDR_W, $clog2(FB_W*FB_H), pixel address width.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  sole clock, rising edge.
  n_rst  in  1  reset, asynchronous, active-low.
  start  in  1  command strobe; sampled in IDLE only.
  x0, y0, x1, y1  in  COORD_W each  endpoint coordinates.
  pattern  in  8  dash mask; bit k enables pixel index k mod 8.
  abort  in  1  cancel current line.
  pix_valid  out  1  pixel output valid.
  pix_ready  in  1  downstream accepts pixel.
  pix_x, pix_y  out  COORD_W each  pixel coordinate.
  pix_addr  out  ADDR_W  pix_y*FB_W + pix_x.
  pix_last  out  1  marks the endpoint (x1,y1) pixel.
  busy  out  1  high in every state except IDLE.
  done  out  1  one-cycle pulse at normal completion.
  pix_count  out  COORD_W+2  pixels emitted for the current or last line.

Function
REQ-003 States SHALL be IDLE, SETUP, RUN and DONE.
REQ-004 In IDLE with start=1, the block SHALL latch x0..y1 and pattern, clear pix_count, and go to SETUP; while busy=1, start SHALL be ignored.
REQ-005 SETUP SHALL compute dx=|x1-x0|, dy=|y1-y0|, sx/sy=+1 when end>start else -1, err=dx-dy, cur=(x0,y0), index k=0, then go to RUN.
REQ-006 Arithmetic SHALL be signed, COORD_W+2 bits for err and e2=2*err, with no overflow for any legal input.
REQ-007 In RUN the current pixel SHALL be visible when cur_x<FB_W, cur_y<FB_H and pattern[k mod 8]=1.
REQ-008 A visible pixel SHALL drive pix_valid=1 and hold x, y, addr and last stable until pix_valid & pix_ready; the step occurs on that cycle.
REQ-009 A non-visible pixel SHALL produce pix_valid=0, consume one cycle, and step without handshake.
REQ-010 Each step SHALL increment k by 1; if e2>-dy: err-=dy, x+=sx; if e2<dx: err+=dx, y+=sy; both updates apply in the same cycle when both conditions hold.
REQ-011 When cur equals (x1,y1), that pixel SHALL be processed per REQ-007..009 with pix_last=1; after it is accepted or skipped, the FSM SHALL go to DONE.
REQ-012 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-013 pix_count SHALL increment once per accepted handshake and hold its value in IDLE.
REQ-014 Throughput SHALL be one pixel per cycle while pix_ready=1; first pix_valid SHALL occur two cycles after the start cycle when pixel 0 is visible.
REQ-015 abort=1 in SETUP, RUN or DONE SHALL force IDLE on the next edge with pix_valid=0 and no done pulse; abort in IDLE SHALL have no effect.
REQ-016 A degenerate line (x0==x1, y0==y1) SHALL yield exactly one pixel with pix_last=1.
REQ-017 pix_valid SHALL be 0 in IDLE, SETUP and DONE.

Reset
REQ-018 n_rst=0 SHALL immediately force IDLE, pix_valid=0, busy=0, done=0, pix_last=0, pix_x=pix_y=pix_addr=0, pix_count=0, with all internal registers at 0.
REQ-019 Reset mid-line SHALL discard the line without a done pulse; the first start after release SHALL behave as from power-up.

Structure
REQ-020 Package raster_pkg SHALL hold the state enum, the signed step-type typedef, and the default FB_W/FB_H constants.
REQ-021 The combinational step (e2, err/x/y update) SHALL be the sub-module raster_step; the FSM and handshake SHALL live in the top.

Verification
REQ-022 (0,0)->(5,2), pattern=FF, ready=1 -> pixels (0,0),(1,0),(2,1),(3,1),(4,2),(5,2); last on (5,2); done one cycle later; pix_count=6.
REQ-023 (5,5)->(5,5) -> single pixel, pix_addr=325, pix_last=1, pix_count=1.
REQ-024 (60,0)->(70,0), FB_W=64 -> only x=60..63 emitted; 11 RUN cycles; done asserted; pix_count=4.
REQ-025 (0,0)->(7,0), pattern=8'b01010101 -> pixels x=0,2,4,6 only; pix_count=4.
REQ-026 (0,0)->(3,3) with pix_ready low for 3 cycles on pixel (1,1) -> outputs hold stable; the sequence is unchanged.
REQ-027 Abort on the 3rd RUN cycle, then start (10,10)->(8,7) -> no done for the first line; the second line emits (10,10),(9,9),(9,8),(8,7).
